// File: rtl/cop0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cop0_regfile: CP0 registers, Count/Compare timer, exception and ERET  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module cop0_regfile #(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc,
  output logic        status_exl,
  output logic        int_pending
);

  localparam int c_tick_w = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(COUNT_DIV - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_resp = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [7:0]          r_im;
  logic                r_exl;
  logic                r_ie;
  logic                r_bd;
  logic                r_ti;
  logic [1:0]          r_ip_sw;
  logic [4:0]          r_exccode;
  logic [31:0]         r_epc;
  logic [31:0]         r_badvaddr;
  logic [31:0]         r_count;
  logic [31:0]         r_compare;
  logic [31:0]         r_rdata;
  logic [c_tick_w-1:0] r_tick;
  logic                r_int_pending;

  logic        w_accept;
  logic        w_wr;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_tick_wrap;
  logic [7:0]  w_ip;
  logic [31:0] w_status_rd;
  logic [31:0] w_cause_rd;
  logic [31:0] w_rd_data;

  assign w_accept     = (r_state == c_st_idle) & req_valid;
  assign w_wr         = w_accept & req_write & (req_sel == 3'd0);
  assign w_wr_count   = w_wr & (req_rd == 5'd9);
  assign w_wr_compare = w_wr & (req_rd == 5'd11);
  assign w_wr_status  = w_wr & (req_rd == 5'd12);
  assign w_wr_cause   = w_wr & (req_rd == 5'd13);
  assign w_wr_epc     = w_wr & (req_rd == 5'd14);
  assign w_tick_wrap  = (r_tick == c_tick_last);

  assign w_ip        = {hw_int[5] | r_ti, hw_int[4:0], r_ip_sw};
  assign w_status_rd = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause_rd  = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

  always_comb begin
    w_rd_data = 32'd0;
    if (req_sel == 3'd0) begin
      case (req_rd)
        5'd8:    w_rd_data = r_badvaddr;
        5'd9:    w_rd_data = r_count;
        5'd11:   w_rd_data = r_compare;
        5'd12:   w_rd_data = w_status_rd;
        5'd13:   w_rd_data = w_cause_rd;
        5'd14:   w_rd_data = r_epc;
        default: w_rd_data = 32'd0;
      endcase
    end
  end

  // Access FSM: state register, next-state, outputs
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= c_st_idle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (req_valid) w_state_nxt = c_st_resp;
      c_st_resp: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == c_st_idle);
    resp_valid = (r_state == c_st_resp);
  end

  assign resp_rdata = r_rdata;

  // Read data is captured before any same-edge write lands
  always_ff @(posedge clk) begin
    if (!resetn)       r_rdata <= 32'd0;
    else if (w_accept) r_rdata <= w_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_tick    <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= req_wdata;
        r_tick  <= '0;
      end else if (w_tick_wrap) begin
        r_count <= r_count + 32'd1;
        r_tick  <= '0;
      end else begin
        r_tick  <= r_tick + 1'b1;
      end
      if (w_wr_compare) r_compare <= req_wdata;
      if (w_wr_compare)
        r_ti <= 1'b0;
      else if (!w_wr_count && w_tick_wrap && ((r_count + 32'd1) == r_compare))
        r_ti <= 1'b1;
    end
  end

  // Exception beats ERET beats MTC0 on EXL/EPC/Cause
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_im       <= STATUS_RESET[15:8];
      r_exl      <= STATUS_RESET[1];
      r_ie       <= STATUS_RESET[0];
      r_bd       <= 1'b0;
      r_ip_sw    <= 2'b00;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      if (w_wr_status) begin
        r_im <= req_wdata[15:8];
        r_ie <= req_wdata[0];
      end
      if (w_wr_status && !exc_valid && !eret) r_exl <= req_wdata[1];
      if (w_wr_cause && !exc_valid) r_ip_sw <= req_wdata[9:8];
      if (w_wr_epc && !exc_valid) r_epc <= req_wdata;
      if (exc_valid) begin
        r_exl     <= 1'b1;
        r_exccode <= exc_code;
        if (!r_exl) begin
          r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          r_bd  <= exc_bd;
        end
        if ((exc_code == 5'd4) || (exc_code == 5'd5)) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_int_pending <= 1'b0;
    else         r_int_pending <= r_ie & ~r_exl & (|(w_ip & r_im));
  end

  assign int_pending = r_int_pending;
  assign epc         = r_epc;
  assign status_exl  = r_exl;

endmodule
`default_nettype wire
